joy_serial_mp: RTL

JOY_SERIAL_MP -- requirements
Module: joy_serial_mp

---
 rtl/joy_serial_pkg.sv | 15 +
 rtl/joy_serial_tick.sv | 25 ++
 rtl/joy_serial_mp.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/joy_serial_pkg.sv
// Shared types and constants for the multi-player serial joypad poller.
package joy_serial_pkg;

  localparam int unsigned MAX_PLAYERS = 4;
  localparam int unsigned OUT_W       = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SAMPLE = 3'd2,
    CLOCK  = 3'd3,
    UPDATE = 3'd4
  } state_t;

endpackage

// File: rtl/joy_serial_tick.sv
// Phase timer: counts 0..DIV-1, flags the terminal count and wraps; restart holds it at 0.
module joy_serial_tick #(
  parameter int unsigned DIV = 24
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_restart,
  output logic o_done_c
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] r_cnt;

  assign o_done_c = (r_cnt == CNT_W'(DIV - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset || i_restart || o_done_c) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/joy_serial_mp.sv
// Polls up to four daisy-chained serial joypads once per frame period.
// Optional JOY_SERIAL_DEBOUNCE_EN: a player's outputs update only after two identical captures.
module joy_serial_mp
  import joy_serial_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS     = 2,
  parameter int unsigned BITS_PER_PLAYER = 12,
  parameter int unsigned CLK_DIV         = 24,
  parameter int unsigned FRAME_CYCLES    = 48000
) (
  input  logic                         clk_sys,
  input  logic                         reset,
  input  logic                         enable,
  output logic                         joy_clk,
  output logic                         joy_load,
  input  logic                         joy_data,
  output logic [NUM_PLAYERS*OUT_W-1:0] joy_out,
  output logic [NUM_PLAYERS-1:0]       joy_valid,
  output logic                         frame_done
);

  localparam int unsigned TOTAL     = NUM_PLAYERS * BITS_PER_PLAYER;
  localparam int unsigned FRAME_LEN = CLK_DIV * (2 * TOTAL) + 1;
  localparam int unsigned IDX_W     = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int unsigned FCNT_W    = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

  if (NUM_PLAYERS < 1 || NUM_PLAYERS > MAX_PLAYERS) begin : g_bad_players
    $error("joy_serial_mp: NUM_PLAYERS out of range");
  end
  if (BITS_PER_PLAYER < 1 || BITS_PER_PLAYER > OUT_W) begin : g_bad_bits
    $error("joy_serial_mp: BITS_PER_PLAYER out of range");
  end
  if (CLK_DIV < 1 || FRAME_CYCLES <= FRAME_LEN) begin : g_bad_frame
    $error("joy_serial_mp: FRAME_CYCLES must exceed the frame length");
  end

  state_t                              r_state;
  state_t                              w_next;
  logic [FCNT_W-1:0]                   r_frame_cnt;
  logic                                w_frame_tick;
  logic [IDX_W-1:0]                    r_idx;
  logic [TOTAL-1:0]                    r_cap;
  logic                                w_phase_done;
  logic                                w_phase_restart;
  logic                                w_last_bit;
  logic                                r_joy_clk;
  logic                                r_joy_load;
  logic [NUM_PLAYERS*OUT_W-1:0]        r_joy_out;
  logic [NUM_PLAYERS-1:0]              r_joy_valid;
  logic                                r_frame_done;
  logic [NUM_PLAYERS-1:0][OUT_W-1:0]   w_word;
  logic [NUM_PLAYERS-1:0]              w_conn;
  logic [NUM_PLAYERS-1:0]              w_upd;

  assign joy_clk    = r_joy_clk;
  assign joy_load   = r_joy_load;
  assign joy_out    = r_joy_out;
  assign joy_valid  = r_joy_valid;
  assign frame_done = r_frame_done;

  // Free-running poll period; the wrap is the frame start request.
  assign w_frame_tick = (r_frame_cnt == FCNT_W'(FRAME_CYCLES - 1));

  always_ff @(posedge clk_sys) begin
    if (reset || w_frame_tick) begin
      r_frame_cnt <= '0;
    end else begin
      r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
    end
  end

  assign w_phase_restart = (r_state == IDLE) || (r_state == UPDATE);
  assign w_last_bit      = (r_idx == IDX_W'(TOTAL - 1));

  joy_serial_tick #(
    .DIV (CLK_DIV)
  ) u_tick (
    .i_clk     (clk_sys),
    .i_reset   (reset),
    .i_restart (w_phase_restart),
    .o_done_c  (w_phase_done)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_frame_tick && enable) w_next = LOAD;
      LOAD:    if (w_phase_done) w_next = SAMPLE;
      SAMPLE:  if (w_phase_done) w_next = w_last_bit ? UPDATE : CLOCK;
      CLOCK:   if (w_phase_done) w_next = SAMPLE;
      UPDATE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Pad strobes are registered from the next state so they line up with r_state.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_cap      <= '0;
      r_joy_load <= 1'b1;
      r_joy_clk  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_joy_load <= (w_next != LOAD);
      r_joy_clk  <= (w_next == CLOCK);
      if (r_state == SAMPLE && w_phase_done) begin
        r_cap[r_idx] <= ~joy_data;
      end
      if (r_state == CLOCK && w_phase_done) begin
        r_idx <= r_idx + IDX_W'(1);
      end else if (r_state == UPDATE) begin
        r_idx <= '0;
      end
    end
  end

`ifdef JOY_SERIAL_DEBOUNCE_EN
  logic [TOTAL-1:0] r_prev;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_prev <= '0;
    end else if (r_state == UPDATE) begin
      r_prev <= r_cap;
    end
  end
`endif

  // An all-ones field means the data line sat low: no pad in that slot.
  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic [BITS_PER_PLAYER-1:0] w_field;
    assign w_field   = r_cap[p*BITS_PER_PLAYER +: BITS_PER_PLAYER];
    assign w_conn[p] = ~&w_field;
    assign w_word[p] = w_conn[p] ? OUT_W'(w_field) : '0;
`ifdef JOY_SERIAL_DEBOUNCE_EN
    assign w_upd[p]  = (w_field == r_prev[p*BITS_PER_PLAYER +: BITS_PER_PLAYER]);
`else
    assign w_upd[p]  = 1'b1;
`endif
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_joy_out    <= '0;
      r_joy_valid  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= (r_state == UPDATE);
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (r_state == UPDATE && w_upd[p]) begin
          r_joy_out[p*OUT_W +: OUT_W] <= w_word[p];
          r_joy_valid[p]              <= w_conn[p];
        end
      end
    end
  end

endmodule
